mips_dmem_arbiter: RTL and testbench

//  Shares the single-port MIPS data memory between two requesters: port 0 is the core load/store

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_rr_pick2.sv | 22 ++
 rtl/mips_dmem_arbiter.sv | 101 ++++++++++
 tb/tb_mips_dmem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS data-memory types: address/data widths, arbiter states and
// the request bundle carried from a requester to the data memory.
package mips_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DATA_W      = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD_WAIT
    } arb_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      wdata;
    } dmem_req_t;

    function automatic logic [1:0] onehot2(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mips_rr_pick2.sv
// Two-way request picker: a single requester wins; on a tie either port 0
// (fixed priority) or the port not granted last time wins.
module mips_rr_pick2
    import mips_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_pri,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = onehot2(!(fixed_pri || last));
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the
// loader/debug master (port 1); one access per grant, reads block until rvalid.
module mips_dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mips_pkg::*;

    localparam int CNT_W = 2;

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;
    logic             owner;
    logic [1:0]       req;
    logic [1:0]       pick;
    logic [1:0]       gnt;
    logic             idle;
    logic             sel1;
    logic             rd_done;

    assign req = {m1_req, m0_req};

    mips_rr_pick2 u_pick (
        .req       (req),
        .last      (last_gnt),
        .fixed_pri (FIXED_PRI),
        .gnt       (pick)
    );

    // rst gates grants so a held request cannot leak a strobe while in reset
    assign idle = rst && (state == ARB_IDLE);
    assign gnt  = idle ? pick : 2'b00;
    assign sel1 = gnt[1];

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign mem_en    = |gnt;
    assign mem_we    = mem_en && (sel1 ? m1_we : m0_we);
    assign mem_addr  = !mem_en ? '0 : (sel1 ? m1_addr : m0_addr);
    assign mem_wdata = !mem_en ? '0 : (sel1 ? m1_wdata : m0_wdata);

    assign rd_done   = (state == ARB_RD_WAIT) && (cnt == '0);
    assign m0_rvalid = rd_done && !owner;
    assign m1_rvalid = rd_done && owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            owner    <= 1'b0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (mem_en) begin
                        last_gnt <= sel1;
                        if (!mem_we) begin
                            owner <= sel1;
                            cnt   <= CNT_W'(MEM_LAT - 1);
                            state <= ARB_RD_WAIT;
                        end
                    end
                end
                ARB_RD_WAIT: begin
                    if (cnt != '0) cnt   <= cnt - 1'b1;
                    else           state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Self-checking bench for mips_dmem_arbiter with a latency-accurate memory
// model and a cycle-level reference model of grants and responses.
module tb_mips_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int L  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic          f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid;
    logic [DW-1:0] f_m0_rdata, f_m1_rdata;
    logic          f_mem_en, f_mem_we;
    logic [AW-1:0] f_mem_addr;
    logic [DW-1:0] f_mem_wdata;
    logic [DW-1:0] f_mem_rdata;
    assign f_mem_rdata = '0;

    mips_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .FIXED_PRI(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mips_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .FIXED_PRI(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata)
    );

    // data memory model: read data appears L cycles after the access cycle
    logic [DW-1:0] mem  [0:1023];
    logic [AW-1:0] pipe [0:L-1];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        pipe[0] <= mem_addr;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = mem[pipe[L-1]];

    int checks = 0;
    int fails  = 0;
    logic [DW-1:0] ref_mem [0:1023];

    task automatic clr();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic chk_quiet(input string name);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            fails++;
            $display("FAIL %s: gnt=%b%b rvalid=%b%b en=%b we=%b addr=%0d wdata=%0h, required all 0",
                     name, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, mem_en, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        #1 chk_quiet("reset_start");
        @(negedge clk);
        rst = 1;
        m0_req = 1; m0_we = 0; m0_addr = 10'd5;
        #1 checks++;
        if (m0_gnt !== 1'b1 || mem_en !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_gnt: m0_gnt=%b mem_en=%b, required 1 1", m0_gnt, mem_en);
        end
        #2 rst = 0;
        #1 chk_quiet("reset_async");
        @(negedge clk);
        clr();
        rst = 1;
        idle(2);
    endtask

    task automatic test_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 10'd20; m0_wdata = 32'd25;
        #1 checks++;
        if (!(m0_gnt === 1 && m1_gnt === 0 && mem_en === 1 && mem_we === 1 &&
              mem_addr === 10'd20 && mem_wdata === 32'd25)) begin
            fails++;
            $display("FAIL wr_issue: gnt=%b%b en=%b we=%b addr=%0d wdata=%0d, required 01 1 1 20 25",
                     m1_gnt, m0_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        m0_we = 0;
        #1 checks++;
        if (m0_gnt !== 1 || mem_en !== 1 || mem_we !== 0 || mem_addr !== 10'd20) begin
            fails++;
            $display("FAIL rd_issue: gnt=%b en=%b we=%b addr=%0d, required 1 1 0 20",
                     m0_gnt, mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        clr();
        for (int k = 1; k <= L; k++) begin
            #1 checks++;
            if (m0_rvalid !== (k == L) || m0_rdata !== ((k == L) ? 32'd25 : 32'd0) ||
                m1_rvalid !== 0 || mem_en !== 0) begin
                fails++;
                $display("FAIL rd_resp k=%0d: rvalid=%b%b rdata=%0d en=%b, required %b0 %0d 0",
                         k, m1_rvalid, m0_rvalid, m0_rdata, mem_en, (k == L), (k == L) ? 25 : 0);
            end
            @(negedge clk);
        end
        idle(1);
    endtask

    task automatic test_round_robin();
        m1_req = 1; m1_we = 1; m1_addr = 10'd21; m1_wdata = 32'd77;
        @(negedge clk);
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 10'd20;
        m1_req = 1; m1_we = 0; m1_addr = 10'd21;
        for (int c = 0; c < 4 * (L + 1); c++) begin
            int ph, w;
            logic [1:0] eg, erv;
            logic [DW-1:0] ed;
            ph  = c % (L + 1);
            w   = (c / (L + 1)) % 2;
            eg  = (ph == 0) ? 2'(1 << w) : 2'b00;
            erv = (ph == L) ? 2'(1 << w) : 2'b00;
            ed  = (w == 1) ? 32'd77 : 32'd25;
            #1 checks++;
            if ({m1_gnt, m0_gnt} !== eg || {m1_rvalid, m0_rvalid} !== erv ||
                m0_rdata !== (erv[0] ? ed : 32'd0) || m1_rdata !== (erv[1] ? ed : 32'd0)) begin
                fails++;
                $display("FAIL rr c=%0d: gnt=%b rvalid=%b rdata=%0d/%0d, required %b %b data %0d",
                         c, {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, m1_rdata, m0_rdata, eg, erv, ed);
            end
            @(negedge clk);
        end
        idle(L + 1);
    endtask

    task automatic test_fixed_pri();
        int n1 = 0;
        m0_req = 1; m0_we = 1; m0_addr = 10'd30; m0_wdata = 32'd1;
        m1_req = 1; m1_we = 1; m1_addr = 10'd31; m1_wdata = 32'd2;
        for (int c = 0; c < 4; c++) begin
            #1 checks++;
            if ({f_m1_gnt, f_m0_gnt} !== 2'b01 || f_mem_addr !== 10'd30) begin
                fails++;
                $display("FAIL fixed_pri c=%0d: gnt=%b addr=%0d, required 01 30",
                         c, {f_m1_gnt, f_m0_gnt}, f_mem_addr);
            end
            if (f_m1_gnt === 1'b1) n1++;
            @(negedge clk);
        end
        checks++;
        if (n1 != 0) begin
            fails++;
            $display("FAIL fixed_pri_m1_count: got %0d, required 0", n1);
        end
        idle(L + 1);
    endtask

    task automatic test_wait_during_read();
        m1_req = 1; m1_we = 0; m1_addr = 10'd21;
        #1 checks++;
        if (m1_gnt !== 1 || m0_gnt !== 0) begin
            fails++;
            $display("FAIL wait_m1_gnt: gnt=%b%b, required 10", m1_gnt, m0_gnt);
        end
        @(negedge clk);
        clr();
        m0_req = 1; m0_we = 0; m0_addr = 10'd20;
        for (int k = 1; k <= L; k++) begin
            #1 checks++;
            if ({m1_gnt, m0_gnt, mem_en} !== 3'b000 || m0_rvalid !== 0 ||
                m1_rvalid !== (k == L) || m1_rdata !== ((k == L) ? 32'd77 : 32'd0)) begin
                fails++;
                $display("FAIL wait_rd k=%0d: gnt=%b%b en=%b rvalid=%b%b rdata=%0d, required 00 0 %b0 %0d",
                         k, m1_gnt, m0_gnt, mem_en, m1_rvalid, m0_rvalid, m1_rdata, (k == L), (k == L) ? 77 : 0);
            end
            @(negedge clk);
        end
        #1 checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0) begin
            fails++;
            $display("FAIL wait_m0_gnt: gnt=%b%b, required 01", m1_gnt, m0_gnt);
        end
        @(negedge clk);
        clr();
        for (int k = 1; k <= L; k++) begin
            #1 checks++;
            if (m0_rvalid !== (k == L) || m0_rdata !== ((k == L) ? 32'd25 : 32'd0) || m1_rvalid !== 0) begin
                fails++;
                $display("FAIL wait_m0_rd k=%0d: rvalid=%b%b rdata=%0d, required 0%b %0d",
                         k, m1_rvalid, m0_rvalid, m0_rdata, (k == L), (k == L) ? 25 : 0);
            end
            @(negedge clk);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_read();
        m1_req = 1; m1_we = 1; m1_addr = 10'd2; m1_wdata = 32'd9;
        @(negedge clk);
        m1_we = 0;
        #1 checks++;
        if (m1_gnt !== 1 || mem_we !== 0) begin
            fails++;
            $display("FAIL rmr_issue: m1_gnt=%b mem_we=%b, required 1 0", m1_gnt, mem_we);
        end
        @(negedge clk);
        clr();
        #1 rst = 0;
        #1 chk_quiet("rmr_async");
        @(negedge clk);
        rst = 1;
        for (int k = 0; k <= L + 1; k++) begin
            #1 checks++;
            if (m1_rvalid !== 0 || m0_rvalid !== 0) begin
                fails++;
                $display("FAIL rmr_stale k=%0d: rvalid=%b%b, required 00", k, m1_rvalid, m0_rvalid);
            end
            @(negedge clk);
        end
        m1_req = 1; m1_we = 0; m1_addr = 10'd2;
        #1 checks++;
        if (m1_gnt !== 1) begin
            fails++;
            $display("FAIL rmr_regnt: m1_gnt=%b, required 1", m1_gnt);
        end
        @(negedge clk);
        clr();
        for (int k = 1; k <= L; k++) begin
            #1 checks++;
            if (m1_rvalid !== (k == L) || m1_rdata !== ((k == L) ? 32'd9 : 32'd0)) begin
                fails++;
                $display("FAIL rmr_reread k=%0d: rvalid=%b rdata=%0d, required %b %0d",
                         k, m1_rvalid, m1_rdata, (k == L), (k == L) ? 9 : 0);
            end
            @(negedge clk);
        end
        idle(1);
    endtask

    task automatic test_random();
        logic          pend [2];
        logic          pwe  [2];
        logic [AW-1:0] pa   [2];
        logic [DW-1:0] pd   [2];
        int free_c = 0, done_c = -1, own = 0, lastp = 1;
        logic [DW-1:0] edat = '0;
        for (int i = 100; i < 108; i++) ref_mem[i] = mem[i];
        pend[0] = 0; pend[1] = 0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            int w;
            logic [1:0] eg, erv;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1;
                    pwe[p]  = 1'($urandom_range(0, 1));
                    pa[p]   = AW'(100 + $urandom_range(0, 7));
                    pd[p]   = $urandom;
                end
            end
            m0_req = pend[0]; m0_we = pwe[0]; m0_addr = pa[0]; m0_wdata = pd[0];
            m1_req = pend[1]; m1_we = pwe[1]; m1_addr = pa[1]; m1_wdata = pd[1];
            w = -1;
            if (c >= free_c) begin
                if (pend[0] && pend[1]) w = (lastp == 1) ? 0 : 1;
                else if (pend[0])       w = 0;
                else if (pend[1])       w = 1;
            end
            eg  = (w < 0) ? 2'b00 : 2'(1 << w);
            erv = (c == done_c) ? 2'(1 << own) : 2'b00;
            #1 checks++;
            if ({m1_gnt, m0_gnt} !== eg || {m1_rvalid, m0_rvalid} !== erv ||
                m0_rdata !== (erv[0] ? edat : '0) || m1_rdata !== (erv[1] ? edat : '0)) begin
                fails++;
                $display("FAIL rand c=%0d: gnt=%b rvalid=%b rdata=%0h/%0h, required %b %b data %0h",
                         c, {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, m1_rdata, m0_rdata, eg, erv, edat);
            end
            if (w >= 0) begin
                checks++;
                if (mem_en !== 1 || mem_addr !== pa[w] || mem_we !== pwe[w] ||
                    (pwe[w] && mem_wdata !== pd[w])) begin
                    fails++;
                    $display("FAIL rand_mem c=%0d: en=%b we=%b addr=%0d wdata=%0h, required 1 %b %0d %0h",
                             c, mem_en, mem_we, mem_addr, mem_wdata, pwe[w], pa[w], pd[w]);
                end
                lastp = w;
                if (pwe[w]) ref_mem[pa[w]] = pd[w];
                else begin
                    done_c = c + L;
                    free_c = c + L + 1;
                    own    = w;
                    edat   = ref_mem[pa[w]];
                end
                pend[w] = 0;
            end
            @(negedge clk);
        end
        idle(L + 2);
    endtask

    initial begin
        rst = 0;
        clr();
        m0_req = 1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_fixed_pri();
        test_wait_during_read();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
